// File: rtl/alu_seq.sv
// alu_seq: registered ALU with NZVC flags and valid/ready handshakes on both
// sides. A result is held in DONE until the consumer takes it. Operands are
// captured on the accept edge.
// Optional feature macro: ALU_SEQ_MUL_EN. When it is defined, op 1000 runs an
// iterative shift-add multiply through the BUSY state. When it is undefined,
// op 1000 is treated as an illegal op.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       nzvc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_NOT = 4'b0101,
        OP_SHL = 4'b0110,
        OP_SHR = 4'b0111,
        OP_MUL = 4'b1000
    } op_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       nzvc_q, nzvc_d;
    logic             accept;

    logic [SHW-1:0]   sh_amt;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_v;
    logic             alu_c;
    logic [3:0]       alu_flags;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [SHW:0] MUL_STEPS = (SHW+1)'(WIDTH);

    logic                 is_mul;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [SHW:0]         cnt_q, cnt_d;
`endif

    // Single-cycle ALU function and flags, evaluated on the presented operands.
    always_comb begin
        sh_amt  = b[SHW-1:0];
        add_ext = {1'b0, a} + {1'b0, b};
        // Top bit is the borrow: it is set only when a < b.
        sub_ext = {1'b0, a} - {1'b0, b};
        // The extra top bit catches the last bit shifted out of the MSB.
        shl_ext = {1'b0, a} << sh_amt;
        // The extra bottom bit catches the last bit shifted out of the LSB.
        // It stays 0 when the shift amount is 0.
        shr_ext = {a, 1'b0} >> sh_amt;
        alu_res = '0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        is_mul  = 1'b0;
`endif
        case (op)
            OP_ADD: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_ext[WIDTH-1:0];
                alu_c   = sub_ext[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_SHL: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: is_mul = 1'b1;
`endif
            // Illegal ops: a zero result gives flags 0100.
            default: alu_res = '0;
        endcase
        alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_v, alu_c};
    end

    // Next-state, handshake outputs and the result/multiplier datapath.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        nzvc_d    = nzvc_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
            end
            S_DONE: begin
                out_valid = 1'b1;
                // The held result retires on the same edge that a new op is accepted.
                in_ready  = out_ready;
                accept    = in_valid & out_ready;
                if (out_ready && !in_valid) begin
                    state_d = S_IDLE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            S_BUSY: begin
                if (cnt_q == MUL_STEPS) begin
                    state_d  = S_DONE;
                    result_d = acc_q[WIDTH-1:0];
                    nzvc_d   = {acc_q[WIDTH-1],
                                (acc_q[WIDTH-1:0] == '0),
                                (acc_q[2*WIDTH-1:WIDTH] != '0),
                                (acc_q[2*WIDTH-1:WIDTH] != '0)};
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            state_d  = S_DONE;
            result_d = alu_res;
            nzvc_d   = alu_flags;
`ifdef ALU_SEQ_MUL_EN
            if (is_mul) begin
                state_d  = S_BUSY;
                result_d = result_q;
                nzvc_d   = nzvc_q;
                acc_d    = '0;
                mcand_d  = {{WIDTH{1'b0}}, a};
                mplier_d = b;
                cnt_d    = '0;
            end
`endif
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Held result and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            nzvc_q   <= '0;
        end else begin
            result_q <= result_d;
            nzvc_q   <= nzvc_d;
        end
    end

`ifdef ALU_SEQ_MUL_EN
    // Shift-add multiplier registers. Reset abandons any multiply in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
`endif

    assign result = result_q;
    assign nzvc   = nzvc_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU with NZVC flags.
- Sits between the datapath register file and the writeback stage.
- Accepts one operation per valid/ready handshake and returns the result and NZVC flags through a registered output handshake.
- Adds back-pressure, a held result register and an optional iterative multiply.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..32.
- SHW, $clog2(WIDTH), derived shift-amount width; do not override.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept an operation this cycle.
- op  input  4  operation code.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer takes result this cycle.
- result  output  WIDTH  registered result.
- nzvc  output  4  registered flags {N,Z,V,C}.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, nzvc=4'b0000, in_ready=1 once reset releases. Reset mid-MUL aborts the operation; no output is produced.
- Accept: occurs when in_valid & in_ready. op, a and b are captured at the accept edge; later input changes have no effect.
- Op codes:
  - 0000 ADD a+b.
  - 0001 SUB a-b.
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 NOT a.
  - 0110 SHL a by b[SHW-1:0].
  - 0111 SHR (logical) a by b[SHW-1:0].
  - 1000 MUL (optional feature).
  - 1001-1111 illegal.
- Flags:
  - N = result[WIDTH-1].
  - Z = (result==0).
  - ADD: C = carry out; V = signed overflow (a,b same sign, result differs).
  - SUB: C = borrow (a<b unsigned); V = signed overflow (a,b differ in sign, result sign != a sign).
  - Logic ops: V=0, C=0.
  - Shifts: V=0, C = last bit shifted out; C=0 when shift amount is 0.
- States:
  - IDLE: in_ready=1. On accept of a single-cycle op, compute and go to DONE. On accept of MUL, go to BUSY.
  - BUSY: in_ready=0. One shift-add step per cycle, WIDTH steps, then go to DONE.
  - DONE: out_valid=1; result and nzvc are held stable until out_ready=1.
    - out_ready=1 and in_valid=0: go to IDLE.
    - in_ready = out_ready in DONE. Simultaneous out_ready and in_valid retires the current result and accepts the new op in the same edge. The next state is DONE (single-cycle op) or BUSY (MUL), with no bubble.
- Latency (accept edge to out_valid high):
  - Single-cycle ops: 1 cycle.
  - MUL: WIDTH+1 cycles.
- Throughput: one single-cycle op per clock when out_ready is held high.
- Illegal op: single-cycle; result=0, nzvc=4'b0100.
- All arithmetic is unsigned WIDTH-bit with wrap-around; result is the low WIDTH bits.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined:
  - op 1000 = unsigned a*b via an iterative shift-add multiplier (BUSY state, 2*WIDTH-bit accumulator).
  - result = low WIDTH bits.
  - C = V = (high WIDTH bits != 0).
  - N and Z are computed from the low half.
- Not defined:
  - op 1000 is illegal: 1-cycle, result=0, nzvc=4'b0100.
  - No BUSY state or accumulator is synthesised; in_ready is 1 in IDLE and follows out_ready in DONE.

Test Plan:
- Reset: drive rst_n=0 mid-stream -> out_valid=0, result=0, nzvc=0000 immediately, without waiting for a clock edge.
- ADD, WIDTH=8: a=0x7F, b=0x01 -> result=0x80, nzvc=1010. Then a=0xFF, b=0x01 -> result=0x00, nzvc=0101. Both appear 1 cycle after accept.
- SUB and shift: SUB a=0x02, b=0x03 -> 0xFF, nzvc=1001. SHL a=0x81, b=1 -> 0x02, nzvc=0001. SHR a=0x01, b=0 -> 0x01, nzvc=0000.
- Back-pressure: hold out_ready=0 for 5 cycles after XOR a=0xFF, b=0xAA -> result=0x55 stays stable and in_ready=0 throughout. Then assert out_ready with in_valid high -> next op is accepted in the same edge with no idle cycle.
- MUL with ALU_SEQ_MUL_EN: a=0x10, b=0x10 -> out_valid high 9 cycles after accept, result=0x00, nzvc=0111, and in_ready=0 while BUSY. Assert rst_n=0 while BUSY -> no output is produced.
- Illegal op 1111, and op 1000 without the macro -> 1-cycle, result=0x00, nzvc=0100.
